// File: rtl/cv32e40n_apu_pkg.sv
// Types shared by the APU responder: opcodes, executor states, queue entry.
// Latency: n/a (types and pure helper functions).
// Backpressure: n/a.
package cv32e40n_apu_pkg;

  typedef enum logic [1:0] {
    APU_OP_ADD   = 2'd0,
    APU_OP_LOAD  = 2'd1,
    APU_OP_STORE = 2'd2,
    APU_OP_XOR   = 2'd3
  } apu_op_e;

  typedef enum logic [2:0] {
    EX_IDLE     = 3'd0,
    EX_EXEC     = 3'd1,
    EX_MEM_REQ  = 3'd2,
    EX_MEM_WAIT = 3'd3,
    EX_RESP     = 3'd4
  } ex_state_e;

  typedef struct packed {
    apu_op_e     op;
    logic [31:0] op0;
    logic [31:0] op1;
  } apu_entry_t;

  localparam logic [3:0] OBI_BE_WORD = 4'b1111;

  // LOAD and STORE go out on the data bus; everything else stays local.
  function automatic logic is_mem_op(apu_op_e op);
    return (op == APU_OP_LOAD) || (op == APU_OP_STORE);
  endfunction

  // Result of the two ALU opcodes; only called for ADD/XOR entries.
  function automatic logic [31:0] alu_result(apu_entry_t e);
    return (e.op == APU_OP_XOR) ? (e.op0 ^ e.op1) : (e.op0 + e.op1);
  endfunction

endpackage

// File: rtl/cv32e40p_apu_core_pkg.sv
// APU port widths shared with the cv32e40p core.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cv32e40p_apu_core_pkg;

  localparam int unsigned APU_NARGS_CPU    = 3;
  localparam int unsigned APU_WOP_CPU      = 6;
  localparam int unsigned APU_NDSFLAGS_CPU = 15;
  localparam int unsigned APU_NUSFLAGS_CPU = 5;

endpackage

// File: rtl/cv32e40n_apu_req_fifo.sv
// In-order request queue for the APU responder, DEPTH entries, head and head+1 visible.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full_o is registered; a push while full is dropped, so callers gate on it.
module cv32e40n_apu_req_fifo
  import cv32e40n_apu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  apu_entry_t push_dat_i,
  input  logic       pop_i,
  output apu_entry_t head_dat_o,
  output apu_entry_t next_dat_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       multi_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occupancy;
  logic [AW-1:0] rd_next_idx;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;
  apu_entry_t    mem_q [DEPTH];

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Pointer advance; full/empty precomputed from next pointers so they come out of flops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Pointer and flag registers; reset simply empties the queue.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  // The executor peeks at head+1 when it retires the head and wants to chain straight on.
  assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);
  assign occupancy   = wr_ptr_q - rd_ptr_q;

  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign next_dat_o = mem_q[rd_next_idx];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign multi_o    = (occupancy >= (AW+1)'(2));

endmodule

// File: rtl/cv32e40n_apu_responder.sv
// APU-side responder: queues requests, runs ADD/XOR with LATENCY cycles, LOAD/STORE over OBI.
// Latency: ALU result LATENCY+1 cycles after accept; memory result 3 cycles plus bus wait.
// Backpressure: apu_gnt_o follows the registered queue-full flag; OBI waits on data_gnt_i.
module cv32e40n_apu_responder
  import cv32e40p_apu_core_pkg::*;
  import cv32e40n_apu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [APU_NARGS_CPU-1:0][31:0]     apu_operands_i,
  input  logic [APU_WOP_CPU-1:0]             apu_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]        apu_flags_i,
  input  logic                               apu_req_i,
  output logic                               apu_gnt_o,
  output logic                               apu_rvalid_o,
  output logic [31:0]                        apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]        apu_flags_o,
  output logic                               mem_master_sel,
  output logic                               data_req_o,
  input  logic                               data_gnt_i,
  input  logic                               data_rvalid_i,
  output logic                               data_we_o,
  output logic [3:0]                         data_be_o,
  output logic [31:0]                        data_addr_o,
  output logic [31:0]                        data_wdata_o,
  input  logic [31:0]                        data_rdata_i
);

  localparam int unsigned    CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  ex_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;

  apu_entry_t req_entry, head, next_head, dispatch;
  logic       push, pop, full, empty, multi, dispatch_vld;
  logic       unused_inputs;

  // Flags in, upper opcode bits and the third operand carry nothing for this block.
  assign unused_inputs = ^{apu_flags_i, apu_op_i, apu_operands_i};

  assign req_entry = '{op:  apu_op_e'(apu_op_i[1:0]),
                       op0: apu_operands_i[0],
                       op1: apu_operands_i[1]};

  // Gated by reset so the core never sees a grant while the queue is being cleared.
  assign apu_gnt_o = rst_ni && !full;
  assign push      = apu_req_i && apu_gnt_o;
  assign pop       = (state_q == EX_RESP);

  cv32e40n_apu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .push_dat_i (req_entry),
    .pop_i      (pop),
    .head_dat_o (head),
    .next_dat_o (next_head),
    .full_o     (full),
    .empty_o    (empty),
    .multi_o    (multi)
  );

  // Pick the entry the executor starts next; an incoming request bypasses an empty queue
  // so an idle executor starts in the cycle right after accept.
  always_comb begin
    dispatch     = req_entry;
    dispatch_vld = 1'b0;
    if (state_q == EX_RESP) begin
      if (multi) begin
        dispatch     = next_head;
        dispatch_vld = 1'b1;
      end else if (push) begin
        dispatch_vld = 1'b1;
      end
    end else begin
      if (!empty) begin
        dispatch     = head;
        dispatch_vld = 1'b1;
      end else if (push) begin
        dispatch_vld = 1'b1;
      end
    end
  end

  // Executor next state, latency countdown and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      EX_IDLE, EX_RESP: begin
        if (!dispatch_vld) begin
          state_d = EX_IDLE;
        end else if (is_mem_op(dispatch.op)) begin
          state_d = EX_MEM_REQ;
        end else begin
          state_d = EX_EXEC;
          cnt_d   = CNT_LOAD;
        end
      end
      EX_EXEC: begin
        if (cnt_q == '0) begin
          result_d = alu_result(head);
          state_d  = EX_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EX_MEM_REQ: begin
        if (data_gnt_i) state_d = EX_MEM_WAIT;
      end
      EX_MEM_WAIT: begin
        if (data_rvalid_i) begin
          result_d = (head.op == APU_OP_LOAD) ? data_rdata_i : 32'h0;
          state_d  = EX_RESP;
        end
      end
      default: state_d = EX_IDLE;
    endcase
  end

  // Executor registers; reset abandons any bus transaction in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= EX_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // OBI driver and APU response, all decoded from state so they are zero when unused.
  always_comb begin
    mem_master_sel = (state_q == EX_MEM_REQ) || (state_q == EX_MEM_WAIT);
    data_req_o     = 1'b0;
    data_we_o      = 1'b0;
    data_be_o      = 4'b0000;
    data_addr_o    = 32'h0;
    data_wdata_o   = 32'h0;
    apu_rvalid_o   = 1'b0;
    apu_result_o   = 32'h0;
    apu_flags_o    = '0;
    if (state_q == EX_MEM_REQ) begin
      data_req_o   = 1'b1;
      data_we_o    = (head.op == APU_OP_STORE);
      data_be_o    = OBI_BE_WORD;
      data_addr_o  = {head.op0[31:2], 2'b00};
      data_wdata_o = head.op1;
    end
    if (state_q == EX_RESP) begin
      apu_rvalid_o   = 1'b1;
      apu_result_o   = result_q;
      apu_flags_o[0] = (result_q == 32'h0);
    end
  end

endmodule
